csa_accum_ctrl: RTL



---
 rtl/csa_accum_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/csa_accum_ctrl.sv
// Operand accumulator keeping a redundant (sum/carry) running total and
// resolving it with one carry-propagate add before a valid/ready hand-off.
module csa_accum_ctrl #(
  parameter int unsigned W    = 5,
  parameter int unsigned CW   = 4,
  parameter int unsigned ACCW = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   count,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_sum,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [ACCW-1:0] s_q, s_d;
  logic [ACCW-1:0] c_q, c_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [ACCW-1:0] sum_q, sum_d;
  logic [ACCW-1:0] x;
  logic [ACCW-1:0] maj;

  assign x   = {{(ACCW-W){1'b0}}, in_data};
  assign maj = (s_q & c_q) | (s_q & x) | (c_q & x);

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = count;
          s_d     = '0;
          c_d     = '0;
          state_d = (count == '0) ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          // 3:2 compression; the majority term carries into the next bit
          s_d   = s_q ^ c_q ^ x;
          c_d   = maj << 1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CW'(1)) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        sum_d   = s_q + c_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
    end
  end

endmodule
